// File: rtl/vga_frame_reader_if.sv
// Avalon-MM burst-read bus between vga_frame_reader (master) and the DDR
// controller (slave).
//
// Handshake: a request is accepted on the rising vga_clk edge where
// avm_read=1 and avm_waitrequest=0. While avm_waitrequest=1 the master holds
// avm_read, avm_address and avm_burstcount unchanged. Read data returns later,
// one 128-bit beat per cycle in which avm_readdatavalid=1, in request order.
// The master cannot stall returning data.
interface vga_frame_reader_if;
    logic [31:0]  avm_address;
    logic         avm_read;
    logic [4:0]   avm_burstcount;
    logic         avm_waitrequest;
    logic [127:0] avm_readdata;
    logic         avm_readdatavalid;

    modport master (
        output avm_address, avm_read, avm_burstcount,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_read, avm_burstcount,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: fetches 32bpp frame-buffer words from DDR with Avalon-MM
// burst reads and pushes every returned beat into the 128-bit pixel FIFO.
// Requests are credit-limited against FIFO free space so the FIFO never
// overflows. Optional double buffering is enabled by defining
// VGA_FRAME_READER_DBLBUF_EN (adds FRAME_BASE_B, fb_sel, fb_active).
// dbg_state exposes the request FSM: 0=IDLE, 1=CHECK, 2=REQ.
module vga_frame_reader #(
    parameter logic [31:0] FRAME_BASE   = 32'h0000_0000,
`ifdef VGA_FRAME_READER_DBLBUF_EN
    parameter logic [31:0] FRAME_BASE_B = 32'h0010_0000,
`endif
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          BURST_LEN    = 16,
    parameter int          FIFO_DEPTH   = 256,
    parameter int          LVL_W        = 9
) (
    input  logic                vga_clk,
    input  logic                vga_reset_n,
    input  logic                enable,
    vga_frame_reader_if.master  avm,
    input  logic [LVL_W-1:0]    fifo_level,
    output logic                fifo_wr_en,
    output logic [127:0]        fifo_wr_data,
    output logic                frame_wrap,
`ifdef VGA_FRAME_READER_DBLBUF_EN
    input  logic                fb_sel,
    output logic                fb_active,
`endif
    output logic [1:0]          dbg_state
);

    localparam int WORDS = H_ACTIVE * V_ACTIVE / 4;
    localparam int OUT_W = LVL_W + 1;
    localparam int CW    = LVL_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_REQ   = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [31:0]      word_idx;
    logic [OUT_W-1:0] outstanding;
    logic [CW-1:0]    credit_sum;
    logic             credit_ok;
    logic             accept;
    logic             last_burst;
    logic [31:0]      base;

    assign accept     = (state == ST_REQ) && !avm.avm_waitrequest;
    assign last_burst = (word_idx + 32'(BURST_LEN)) == 32'(WORDS);
    assign credit_sum = CW'(fifo_level) + CW'(outstanding) + CW'(BURST_LEN);
    assign credit_ok  = credit_sum <= CW'(FIFO_DEPTH);

`ifdef VGA_FRAME_READER_DBLBUF_EN
    assign base = fb_active ? FRAME_BASE_B : FRAME_BASE;
`else
    assign base = FRAME_BASE;
`endif

    // Bus outputs follow the registered state, so they cannot change while a
    // request waits. Burstcount reads 0 outside a request so reset leaves
    // every output low.
    assign avm.avm_read       = (state == ST_REQ);
    assign avm.avm_burstcount = avm.avm_read ? 5'(BURST_LEN) : 5'd0;
    assign avm.avm_address    = base + (word_idx << 4);
    assign frame_wrap         = accept && last_burst;
    assign dbg_state          = state;

    // Request FSM: next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (enable) next_state = ST_CHECK;
            ST_CHECK: begin
                if (!enable)        next_state = ST_IDLE;
                else if (credit_ok) next_state = ST_REQ;
            end
            ST_REQ:   if (accept) next_state = enable ? ST_CHECK : ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Request FSM: state register.
    always_ff @(posedge vga_clk or negedge vga_reset_n) begin
        if (!vga_reset_n) state <= ST_IDLE;
        else              state <= next_state;
    end

    // Frame word pointer: advances per accepted burst, wraps at frame end,
    // and restarts at the frame start whenever the reader goes idle.
    always_ff @(posedge vga_clk or negedge vga_reset_n) begin
        if (!vga_reset_n)                 word_idx <= '0;
        else if (next_state == ST_IDLE)   word_idx <= '0;
        else if (accept)                  word_idx <= last_burst ? 32'd0 : word_idx + 32'(BURST_LEN);
    end

    // Words requested but not yet written into the FIFO.
    always_ff @(posedge vga_clk or negedge vga_reset_n) begin
        if (!vga_reset_n) outstanding <= '0;
        else begin
            case ({accept, fifo_wr_en})
                2'b10:   outstanding <= outstanding + OUT_W'(BURST_LEN);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                2'b11:   outstanding <= outstanding + OUT_W'(BURST_LEN - 1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Every returned beat goes to the FIFO one cycle later, even when idle.
    always_ff @(posedge vga_clk or negedge vga_reset_n) begin
        if (!vga_reset_n) begin
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
        end else begin
            fifo_wr_en   <= avm.avm_readdatavalid;
            fifo_wr_data <= avm.avm_readdata;
        end
    end

`ifdef VGA_FRAME_READER_DBLBUF_EN
    // Buffer select is only taken at a frame boundary so a frame is never split.
    always_ff @(posedge vga_clk or negedge vga_reset_n) begin
        if (!vga_reset_n)
            fb_active <= 1'b0;
        else if (frame_wrap || (state == ST_IDLE && next_state == ST_CHECK))
            fb_active <= fb_sel;
    end
`endif

endmodule
